// File: rtl/led_nios2_processor_jtag_scan_master.sv
// Virtual-JTAG scan initiator for the Nios II debug module: takes one IR+DR command,
// generates a divided TCK, walks UIR/CDR/SDR/UDR/RTI and returns the captured TDO word.
module led_nios2_processor_jtag_scan_master #(
  parameter int DR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int TCK_DIV     = 2,
  parameter int RTI_PERIODS = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                busy,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti,
  output logic [2:0]          state_dbg
);

  localparam int HC_W   = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam int PC_MAX = (DR_WIDTH > RTI_PERIODS) ? DR_WIDTH : RTI_PERIODS;
  localparam int PC_W   = (PC_MAX > 1) ? $clog2(PC_MAX) : 1;

  localparam logic [HC_W-1:0] HC_LAST     = HC_W'(TCK_DIV - 1);
  localparam logic [PC_W-1:0] PC_SDR_LAST = PC_W'(DR_WIDTH - 1);
  localparam logic [PC_W-1:0] PC_RTI_LAST = PC_W'(RTI_PERIODS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_UIR  = 3'd1,
    S_CDR  = 3'd2,
    S_SDR  = 3'd3,
    S_UDR  = 3'd4,
    S_RTI  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t              state;
  logic [HC_W-1:0]     half_cnt;
  logic [PC_W-1:0]     per_cnt;
  logic [DR_WIDTH-1:0] sr;
  logic                phase_end;

  // Handshake: a command transfers on any clk where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, and rsp_valid is an unconditional one-clk pulse.
  assign phase_end = (half_cnt == HC_LAST);
  assign state_dbg = state;

  function automatic logic [DR_WIDTH-1:0] shift_in(input logic [DR_WIDTH-1:0] v,
                                                   input logic b);
    logic [DR_WIDTH-1:0] r;
    r = v >> 1;
    r[DR_WIDTH-1] = b;
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      half_cnt  <= '0;
      per_cnt   <= '0;
      sr        <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
      vji_tck   <= 1'b0;
      vji_tdi   <= 1'b0;
      vji_ir_in <= '0;
      vji_uir   <= 1'b0;
      vji_cdr   <= 1'b0;
      vji_sdr   <= 1'b0;
      vji_udr   <= 1'b0;
      vji_rti   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            state     <= S_UIR;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            sr        <= cmd_data;
            vji_ir_in <= cmd_ir;
            vji_uir   <= 1'b1;
            half_cnt  <= '0;
            per_cnt   <= '0;
            vji_tck   <= 1'b0;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          if (!phase_end) begin
            half_cnt <= half_cnt + 1'b1;
          end else if (!vji_tck) begin
            // Last clk of the low phase: TCK rises and TDO is captured at the MSB.
            half_cnt <= '0;
            vji_tck  <= 1'b1;
            if (state == S_SDR) sr <= shift_in(sr, vji_tdo);
          end else begin
            // End of a period: every flag/TDI change lands on the next low-phase start.
            half_cnt <= '0;
            vji_tck  <= 1'b0;
            case (state)
              S_UIR: begin
                state   <= S_CDR;
                vji_uir <= 1'b0;
                vji_cdr <= 1'b1;
              end
              S_CDR: begin
                state   <= S_SDR;
                vji_cdr <= 1'b0;
                vji_sdr <= 1'b1;
                vji_tdi <= sr[0];
              end
              S_SDR: begin
                if (per_cnt == PC_SDR_LAST) begin
                  state   <= S_UDR;
                  per_cnt <= '0;
                  vji_sdr <= 1'b0;
                  vji_tdi <= 1'b0;
                  vji_udr <= 1'b1;
                end else begin
                  per_cnt <= per_cnt + 1'b1;
                  vji_tdi <= sr[0];
                end
              end
              S_UDR: begin
                state   <= S_RTI;
                vji_udr <= 1'b0;
                vji_rti <= 1'b1;
              end
              S_RTI: begin
                if (per_cnt == PC_RTI_LAST) begin
                  state     <= S_DONE;
                  per_cnt   <= '0;
                  vji_rti   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_data  <= sr;
                  busy      <= 1'b0;
                end else begin
                  per_cnt <= per_cnt + 1'b1;
                end
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_nios2_processor_jtag_scan_master.sv
// Bench for the scan master: loopback debug-module model on the default build, plus
// TCK_DIV=1 and TCK_DIV=3 builds with TDO tied high.
module tb_led_nios2_processor_jtag_scan_master;

  localparam int DW = 38;
  localparam int IW = 2;
  localparam int LAT_DEF = 1 + 43 * 2 * 2;
  localparam int LAT_D1  = 1 + 43 * 2 * 1;
  localparam int LAT_D3  = 1 + 43 * 2 * 3;
  localparam logic [DW-1:0] CDR_DEF = 38'h2_A5A5_5A5A;
  localparam logic [DW-1:0] ALL_ONE = 38'h3F_FFFF_FFFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic          cmd_valid, v1_valid, v2_valid;
  logic [IW-1:0] cmd_ir;
  logic [DW-1:0] cmd_data;

  logic          cmd_ready, rsp_valid, busy, vji_tck, vji_tdi, vji_tdo;
  logic [DW-1:0] rsp_data;
  logic [IW-1:0] vji_ir_in;
  logic          vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
  logic [2:0]    state_dbg;

  logic          ready1, rv1, busy1, tck1, tdi1, uir1, cdr1, sdr1, udr1, rti1;
  logic [DW-1:0] rd1;
  logic [IW-1:0] ir1;
  logic [2:0]    st1;
  logic          ready2, rv2, busy2, tck2, tdi2, uir2, cdr2, sdr2, udr2, rti2;
  logic [DW-1:0] rd2;
  logic [IW-1:0] ir2;
  logic [2:0]    st2;

  led_nios2_processor_jtag_scan_master dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
    .vji_ir_in(vji_ir_in), .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr),
    .vji_udr(vji_udr), .vji_rti(vji_rti), .state_dbg(state_dbg)
  );

  led_nios2_processor_jtag_scan_master #(.TCK_DIV(1)) dut_d1 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(v1_valid), .cmd_ready(ready1),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rv1), .rsp_data(rd1),
    .busy(busy1), .vji_tck(tck1), .vji_tdi(tdi1), .vji_tdo(1'b1),
    .vji_ir_in(ir1), .vji_uir(uir1), .vji_cdr(cdr1), .vji_sdr(sdr1),
    .vji_udr(udr1), .vji_rti(rti1), .state_dbg(st1)
  );

  led_nios2_processor_jtag_scan_master #(.TCK_DIV(3)) dut_d3 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(v2_valid), .cmd_ready(ready2),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rv2), .rsp_data(rd2),
    .busy(busy2), .vji_tck(tck2), .vji_tdi(tdi2), .vji_tdo(1'b1),
    .vji_ir_in(ir2), .vji_uir(uir2), .vji_cdr(cdr2), .vji_sdr(sdr2),
    .vji_udr(udr2), .vji_rti(rti2), .state_dbg(st2)
  );

  // ---------------- loopback debug-module model ----------------
  logic [DW-1:0] lb_sr;
  logic [DW-1:0] cdr_val;
  always @(posedge vji_tck) begin
    if (vji_cdr)      lb_sr <= cdr_val;
    else if (vji_sdr) lb_sr <= {vji_tdi, lb_sr[DW-1:1]};
  end
  assign vji_tdo = lb_sr[0];

  // ---------------- monitor (sampled on the falling edge) ----------------
  int acc_cnt = 0, last_acc = 0, rsp_cnt = 0, last_rsp = 0;
  int rises = 0, n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0, n_rti = 0;
  int v_onehot = 0, v_tdi = 0, v_tck_idle = 0, v_wide = 0, v_busy_acc = 0;
  int rsp_cyc_q[$];
  logic [DW-1:0] rsp_q[$];
  logic prev_tck = 1'b0, prev_rv = 1'b0;

  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) begin
      acc_cnt++;
      last_acc = cyc;
      if (busy) v_busy_acc++;
    end
    if ($countones({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}) > 1) v_onehot++;
    if (vji_tdi && !vji_sdr) v_tdi++;
    if (vji_tck && (cmd_ready || rsp_valid)) v_tck_idle++;
    if (vji_tck && !prev_tck) begin
      rises++;
      if (vji_uir) n_uir++;
      if (vji_cdr) n_cdr++;
      if (vji_sdr) n_sdr++;
      if (vji_udr) n_udr++;
      if (vji_rti) n_rti++;
    end
    if (rsp_valid) begin
      rsp_cnt++;
      last_rsp = cyc;
      rsp_cyc_q.push_back(cyc);
      rsp_q.push_back(rsp_data);
      if (prev_rv) v_wide++;
    end
    prev_tck = vji_tck;
    prev_rv  = rsp_valid;
  end

  // ---------------- scoreboard ----------------
  int passed = 0;
  int total  = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [IW-1:0] ir, input logic [DW-1:0] data);
    int a0, t;
    a0 = acc_cnt;
    cmd_ir = ir;
    cmd_data = data;
    cmd_valid = 1'b1;
    t = 0;
    while (acc_cnt == a0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("accept_timeout", 64'(acc_cnt - a0), 64'd1);
    cmd_valid = 1'b0;
    cmd_ir = IW'($urandom);
    cmd_data = DW'({$urandom, $urandom});
  endtask

  task automatic run_scan(input string tag, input logic [IW-1:0] ir,
                          input logic [DW-1:0] data, input logic [DW-1:0] cdr,
                          input logic [DW-1:0] exp_rsp, input logic [DW-1:0] exp_sr);
    int r0, t, k0, u0, c0, s0, d0, ti0;
    logic [DW-1:0] exp;
    r0 = rsp_cnt; k0 = rises; u0 = n_uir; c0 = n_cdr; s0 = n_sdr; d0 = n_udr; ti0 = n_rti;
    cdr_val = cdr;
    exp_q.push_back(exp_rsp);
    issue(ir, data);
    t = 0;
    while (rsp_cnt == r0 && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    check({tag, "_rsp_seen"}, 64'(rsp_cnt - r0), 64'd1);
    check({tag, "_latency"}, 64'(last_rsp - last_acc), 64'(LAT_DEF));
    exp = exp_q.pop_front();
    check({tag, "_rsp_data"}, (rsp_q.size() > r0) ? rsp_q[r0] : 'x, exp);
    repeat (2) @(negedge clk);
    check({tag, "_rsp_hold"}, rsp_data, exp);
    check({tag, "_ready_back"}, {cmd_ready, busy, rsp_valid}, 3'b100);
    check({tag, "_model_sr"}, lb_sr, exp_sr);
    check({tag, "_ir_in"}, vji_ir_in, ir);
    check({tag, "_tck_rises"}, 64'(rises - k0), 64'd43);
    check({tag, "_flag_rises"},
          {16'(n_uir - u0), 16'(n_cdr - c0), 16'(n_sdr - s0), 8'(n_udr - d0), 8'(n_rti - ti0)},
          {16'd1, 16'd1, 16'd38, 8'd1, 8'd2});
  endtask

  // ---------------- stimulus tables ----------------
  typedef struct {
    logic [IW-1:0] ir;
    logic [DW-1:0] data;
    logic [DW-1:0] cdr;
    logic [DW-1:0] exp_rsp;
    logic [DW-1:0] exp_sr;
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int a0, r0, t, c1, c3, acc_c;
    int bb_acc[3];
    logic got1, got3;
    logic [DW-1:0] d1, d3, rnd_cdr;

    reset_n = 1'b0;
    cmd_valid = 1'b0; v1_valid = 1'b0; v2_valid = 1'b0;
    cmd_ir = '0; cmd_data = '0; cdr_val = CDR_DEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {cmd_ready, rsp_valid, rsp_data, busy, vji_tck, vji_tdi, vji_ir_in,
           vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, state_dbg}, '0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_reset", {cmd_ready, busy}, 2'b10);

    vecs[0] = '{2'b10, 38'h1_2345_6789, CDR_DEF, CDR_DEF, 38'h1_2345_6789};
    vecs[1] = '{2'b01, 38'h3F_FFFF_FFFF, 38'h0, 38'h0, 38'h3F_FFFF_FFFF};
    vecs[2] = '{2'b11, 38'h0, ALL_ONE, ALL_ONE, 38'h0};
    vecs[3] = '{2'b00, 38'h2A_AAAA_AAAA, 38'h15_5555_5555, 38'h15_5555_5555, 38'h2A_AAAA_AAAA};
    for (int i = 4; i < 8; i++) begin
      vecs[i].ir = IW'($urandom_range(0, 3));
      vecs[i].data = DW'({$urandom, $urandom});
      vecs[i].cdr = DW'({$urandom, $urandom});
      vecs[i].exp_rsp = vecs[i].cdr;
      vecs[i].exp_sr = vecs[i].data;
    end
    for (int i = 0; i < 8; i++) begin
      run_scan($sformatf("vec%0d", i), vecs[i].ir, vecs[i].data, vecs[i].cdr,
               vecs[i].exp_rsp, vecs[i].exp_sr);
    end

    // Back-to-back: cmd_valid held high across three commands.
    rnd_cdr = DW'({$urandom, $urandom});
    cdr_val = rnd_cdr;
    a0 = acc_cnt; r0 = rsp_cnt;
    cmd_valid = 1'b1;
    cmd_ir = 2'b01; cmd_data = 38'h0F_0F0F_0F0F;
    for (int k = 0; k < 3; k++) begin
      t = 0;
      while (acc_cnt == a0 + k && t < 400) begin
        @(posedge clk); #1;
        t++;
      end
      bb_acc[k] = last_acc;
      cmd_data = DW'({$urandom, $urandom});
      if (k == 2) cmd_valid = 1'b0;
    end
    check("b2b_accepts", 64'(acc_cnt - a0), 64'd3);
    t = 0;
    while (rsp_cnt < r0 + 3 && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    check("b2b_rsps", 64'(rsp_cnt - r0), 64'd3);
    for (int k = 0; k < 3; k++)
      check($sformatf("b2b_rsp%0d", k), (rsp_q.size() > r0 + k) ? rsp_q[r0 + k] : 'x, rnd_cdr);
    for (int k = 1; k < 3; k++)
      check($sformatf("b2b_gap%0d", k), 64'(bb_acc[k]),
            (rsp_cyc_q.size() > r0 + k - 1) ? 64'(rsp_cyc_q[r0 + k - 1] + 1) : 64'hx);

    // Reset during SDR shift 20 aborts the scan without a response.
    cdr_val = CDR_DEF;
    a0 = rises;
    issue(2'b11, 38'h2_0000_0001);
    t = 0;
    while (rises - a0 < 22 && t < 400) begin
      @(negedge clk);
      t++;
    end
    while (vji_tck && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("rst_reached_sdr", vji_sdr, 1'b1);
    r0 = rsp_cnt;
    reset_n = 1'b0;
    #1;
    check("rst_async_outputs",
          {cmd_ready, rsp_valid, rsp_data, busy, vji_tck, vji_tdi, vji_ir_in,
           vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, state_dbg}, '0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (400) @(negedge clk);
    check("rst_no_rsp", 64'(rsp_cnt - r0), 64'd0);
    check("rst_rsp_data", rsp_data, '0);
    run_scan("post_rst", 2'b01, 38'h1_2345_6789, CDR_DEF, CDR_DEF, 38'h1_2345_6789);

    // TCK_DIV sweep with TDO tied high.
    cmd_ir = 2'b10; cmd_data = DW'({$urandom, $urandom});
    @(posedge clk); #1 v1_valid = 1'b1; v2_valid = 1'b1;
    @(negedge clk);
    acc_c = cyc;
    check("sweep_ready", {ready1, ready2}, 2'b11);
    @(posedge clk); #1 v1_valid = 1'b0; v2_valid = 1'b0;
    got1 = 1'b0; got3 = 1'b0; c1 = 0; c3 = 0; d1 = '0; d3 = '0;
    for (int i = 0; i < 400 && !(got1 && got3); i++) begin
      @(negedge clk);
      if (rv1 && !got1) begin got1 = 1'b1; c1 = cyc; d1 = rd1; end
      if (rv2 && !got3) begin got3 = 1'b1; c3 = cyc; d3 = rd2; end
    end
    check("div1_seen", got1, 1'b1);
    check("div3_seen", got3, 1'b1);
    check("div1_latency", 64'(c1 - acc_c), 64'(LAT_D1));
    check("div3_latency", 64'(c3 - acc_c), 64'(LAT_D3));
    check("div1_rsp", d1, ALL_ONE);
    check("div3_rsp", d3, ALL_ONE);
    check("div_ir_in", {ir1, ir2}, 4'b1010);

    repeat (4) @(negedge clk);
    check("onehot_flags", 64'(v_onehot), 64'd0);
    check("tdi_outside_sdr", 64'(v_tdi), 64'd0);
    check("tck_in_idle_done", 64'(v_tck_idle), 64'd0);
    check("rsp_pulse_width", 64'(v_wide), 64'd0);
    check("accept_while_busy", 64'(v_busy_acc), 64'd0);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/led_nios2_processor_jtag_scan_master.md
# led_nios2_processor_jtag_scan_master

Single-clock scan initiator that drives the virtual-JTAG side of the Nios II debug module (the `vji_*` signal set consumed by the debug module's TCK and SYSCLK halves). It accepts one command at a time, made of a 2-bit IR value and a 38-bit DR word, and generates a divided TCK. It sequences UIR → CDR → SDR (38 shifts) → UDR → RTI, shifts the DR word out LSB first on TDI, and returns the 38 TDO bits captured during the shift. It is used in simulation and in on-chip self-test to exercise debug-module register access without a JTAG cable.

## Interface
Parameters:
- `DR_WIDTH`, 38, scan data register length in bits.
- `IR_WIDTH`, 2, virtual IR width.
- `TCK_DIV`, 2, clk cycles per TCK half-period; legal values ≥ 1.
- `RTI_PERIODS`, 2, TCK periods spent in RTI after UDR; legal values ≥ 1.

Ports:
- `clk`  in  1  system clock; every register is clocked on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_ir`  in  IR_WIDTH  IR value to apply at UIR.
- `cmd_data`  in  DR_WIDTH  word to shift out on TDI.
- `rsp_valid`  out  1  one-clk pulse when the scan completes.
- `rsp_data`  out  DR_WIDTH  captured TDO word, held until the next rsp_valid.
- `busy`  out  1  high from the accept cycle +1 until rsp_valid.
- `vji_tck`  out  1  generated TCK.
- `vji_tdi`  out  1  serial data out.
- `vji_tdo`  in  1  serial data in from the debug module.
- `vji_ir_in`  out  IR_WIDTH  virtual IR value.
- `vji_uir`, `vji_cdr`, `vji_sdr`, `vji_udr`, `vji_rti`  out  1 each  virtual state flags.

## Operation
States: IDLE, UIR, CDR, SDR, UDR, RTI, DONE.

Acceptance and latching:
- A command is accepted when `cmd_valid && cmd_ready`. At acceptance the block latches `cmd_ir` and `cmd_data` into a DR_WIDTH shift register, clears the shift counter, and enters UIR on the next clk.

TCK periods:
- Each non-IDLE/DONE state lasts a whole number of TCK periods.
- A TCK period is TCK_DIV clk cycles with `vji_tck`=0, then TCK_DIV cycles with `vji_tck`=1.
- All state flags, `vji_tdi` and `vji_ir_in` change only on the clk edge that starts a low phase. They are therefore stable across the TCK rising edge.

Behaviour per state:
- UIR: 1 period. `vji_uir`=1 and `vji_ir_in`=latched IR. `vji_ir_in` then holds that value until the next UIR or reset.
- CDR: 1 period, `vji_cdr`=1.
- SDR: DR_WIDTH periods, `vji_sdr`=1.
  - In period i (0..DR_WIDTH-1), `vji_tdi`=cmd_data[i].
  - `vji_tdo` is sampled on the last clk of the low phase of period i and stored as rsp bit i.
  - The shift register shifts right, inserting the TDO sample at the MSB.
- UDR: 1 period, `vji_udr`=1.
- RTI: RTI_PERIODS periods, `vji_rti`=1.
- DONE: 1 clk. `rsp_valid`=1, `rsp_data` is updated, the block returns to IDLE, and `cmd_ready` rises on the next clk.

Signal rules:
- At most one state flag is high at any time. All flags are 0 in IDLE and DONE.
- `vji_tck`=0 in IDLE and DONE.
- `vji_tdi`=0 outside SDR.
- `cmd_valid` is ignored while busy. Command inputs may change freely after acceptance.

## Timing
Reset values:
- While `reset_n`=0, and immediately (asynchronously) when it falls: `cmd_ready`=1 after release, `rsp_valid`=0, `rsp_data`=0, `busy`=0, `vji_tck`=0, `vji_tdi`=0, `vji_ir_in`=0, all flags 0, state IDLE.
- Reset mid-scan aborts the scan with no `rsp_valid` and no partial `rsp_data` update.

Latency:
- Total TCK periods P = 3 + DR_WIDTH + RTI_PERIODS.
- If a command is accepted at clk N, `rsp_valid` is high at clk N + 1 + P·2·TCK_DIV. With defaults this is N+173.
- The earliest next acceptance is clk N+174, so back-to-back commands leave one IDLE clk between scans.

Counters:
- The half-period counter is ceil(log2(TCK_DIV)) bits wide.
- The period counter covers max(DR_WIDTH, RTI_PERIODS). It wraps to 0 on each state change and never exceeds its terminal count.

Boundary cases:
- With TCK_DIV=1, the TDO sample falls in the single low-phase clk.
- With a DR_WIDTH=1 build, SDR lasts exactly 1 period.

## Test plan
- Loopback model (38-bit shift register clocked on `vji_tck` rising edge while `vji_sdr`; `vji_tdo`=sr[0]; CDR loads 38'h2_A5A5_5A5A). Send cmd_data=38'h1_2345_6789, cmd_ir=2'b10 → rsp_data=38'h2_A5A5_5A5A, model sr=38'h1_2345_6789 at UDR, `vji_ir_in`=2'b10 from UIR onward.
- Defaults, accept at clk 10 → `rsp_valid` exactly at clk 183, one cycle wide. Exactly 43 `vji_tck` rising edges: 1 UIR, 1 CDR, 38 SDR, 1 UDR, 2 RTI. Flags are never simultaneously high.
- Hold `cmd_valid`=1 continuously with 3 different commands → 3 responses, each accept 1 clk after the previous `rsp_valid`. No command is accepted while `busy`.
- Assert `reset_n`=0 during SDR shift 20 → all outputs are 0 within the same cycle, no `rsp_valid`, `rsp_data` keeps 0. A new command after release completes normally.
- Parameter sweep TCK_DIV=1 and 3 with `vji_tdo` tied 1 → rsp_data=38'h3F_FFFF_FFFF. Latency is 1+43·2 = 87 and 1+43·6 = 259 clks respectively.
